// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ISTALL = 2'd1,
        DSTALL = 2'd2,
        BUBBLE = 2'd3
    } stall_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    localparam logic [2:0] PERF_CYCLES = 3'd0;
    localparam logic [2:0] PERF_ISTALL = 3'd1;
    localparam logic [2:0] PERF_DSTALL = 3'd2;
    localparam logic [2:0] PERF_BUBBLE = 3'd3;
    localparam logic [2:0] PERF_FLUSH  = 3'd4;

    // Operand source for one EX register; the younger writer (MEM) wins over WB.
    function automatic fwd_sel_t fwd_pick(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_wr,
        input logic [4:0] wb_rd,
        input logic       wb_wr
    );
        if (mem_wr && mem_rd != 5'd0 && mem_rd == rs)
            return FWD_MEM;
        else if (wb_wr && wb_rd != 5'd0 && wb_rd == rs)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Performance counters for stall/flush events with a registered read port.
module hazard_perf_cnt
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc_cycle,
    input  logic             inc_istall,
    input  logic             inc_dstall,
    input  logic             inc_bubble,
    input  logic             inc_flush,
    input  logic [2:0]       sel,
    output logic [CNT_W-1:0] data
);

    logic [CNT_W-1:0] cnt_cycle;
    logic [CNT_W-1:0] cnt_istall;
    logic [CNT_W-1:0] cnt_dstall;
    logic [CNT_W-1:0] cnt_bubble;
    logic [CNT_W-1:0] cnt_flush;
    logic [CNT_W-1:0] sel_val;

    // Event counters: clear beats increment, wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt_cycle  <= '0;
            cnt_istall <= '0;
            cnt_dstall <= '0;
            cnt_bubble <= '0;
            cnt_flush  <= '0;
        end else begin
            cnt_cycle  <= cnt_cycle  + CNT_W'(inc_cycle);
            cnt_istall <= cnt_istall + CNT_W'(inc_istall);
            cnt_dstall <= cnt_dstall + CNT_W'(inc_dstall);
            cnt_bubble <= cnt_bubble + CNT_W'(inc_bubble);
            cnt_flush  <= cnt_flush  + CNT_W'(inc_flush);
        end
    end

    // Counter select; unused codes read as zero.
    always_comb begin
        sel_val = '0;
        case (sel)
            PERF_CYCLES: sel_val = cnt_cycle;
            PERF_ISTALL: sel_val = cnt_istall;
            PERF_DSTALL: sel_val = cnt_dstall;
            PERF_BUBBLE: sel_val = cnt_bubble;
            PERF_FLUSH:  sel_val = cnt_flush;
            default:     sel_val = '0;
        endcase
    end

    // Registered read port, one cycle behind the select.
    always_ff @(posedge clk) begin
        if (!rst)
            data <= '0;
        else
            data <= sel_val;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall, flush and forwarding control for the 5-stage RV32I pipeline.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_dcache_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_load_regfile,
    input  logic [4:0]       wb_rd,
    input  logic             wb_load_regfile,
    input  logic             ex_redirect,
    input  logic             icache_resp,
    input  logic             dcache_req,
    input  logic             dcache_resp,
    input  logic             perf_clr,
    input  logic [2:0]       perf_sel,
    output logic             load_pc,
    output logic             pipe_load_ifid,
    output logic             pipe_load_idex,
    output logic             pipe_load_exmem,
    output logic             pipe_load_memwb,
    output logic             pipe_rst_ifid,
    output logic             pipe_rst_idex,
    output logic             pipe_rst_exmem,
    output logic             pipe_rst_memwb,
    output logic [1:0]       rs1mux_sel,
    output logic [1:0]       rs2mux_sel,
    output logic [1:0]       stall_state,
    output logic [CNT_W-1:0] perf_data
);

    stall_state_t state_q;
    stall_state_t state_d;
    logic         dstall;
    logic         istall;
    logic         lu;
    logic         ev_istall;
    logic         ev_dstall;
    logic         ev_bubble;
    logic         ev_flush;

    assign dstall = dcache_req & ~dcache_resp;
    assign istall = ~icache_resp;
    assign lu     = ex_dcache_read & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // Stall-reason register; reset returns to RUN.
    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // Priority resolution dstall > redirect > istall > load-use > run.
    always_comb begin
        state_d         = RUN;
        load_pc         = 1'b1;
        pipe_load_ifid  = 1'b1;
        pipe_load_idex  = 1'b1;
        pipe_load_exmem = 1'b1;
        pipe_load_memwb = 1'b1;
        pipe_rst_ifid   = 1'b0;
        pipe_rst_idex   = 1'b0;
        pipe_rst_exmem  = 1'b0;
        pipe_rst_memwb  = 1'b0;
        ev_istall       = 1'b0;
        ev_dstall       = 1'b0;
        ev_bubble       = 1'b0;
        ev_flush        = 1'b0;
        if (!rst) begin
            load_pc        = 1'b0;
            pipe_rst_ifid  = 1'b1;
            pipe_rst_idex  = 1'b1;
            pipe_rst_exmem = 1'b1;
            pipe_rst_memwb = 1'b1;
        end else if (dstall || (ex_redirect && istall)) begin
            // Full freeze; a pending redirect stays in EX until it can apply.
            load_pc         = 1'b0;
            pipe_load_ifid  = 1'b0;
            pipe_load_idex  = 1'b0;
            pipe_load_exmem = 1'b0;
            pipe_load_memwb = 1'b0;
            state_d         = dstall ? DSTALL : ISTALL;
            ev_dstall       = dstall;
            ev_istall       = ~dstall;
        end else if (ex_redirect) begin
            pipe_rst_ifid = 1'b1;
            pipe_rst_idex = 1'b1;
            ev_flush      = 1'b1;
        end else if (istall || lu) begin
            load_pc        = 1'b0;
            pipe_load_ifid = 1'b0;
            pipe_rst_idex  = 1'b1;
            state_d        = istall ? ISTALL : BUBBLE;
            ev_istall      = istall;
            ev_bubble      = ~istall;
        end
    end

    assign stall_state = state_q;
    assign rs1mux_sel  = rst ? fwd_pick(ex_rs1, mem_rd, mem_load_regfile, wb_rd, wb_load_regfile) : FWD_RF;
    assign rs2mux_sel  = rst ? fwd_pick(ex_rs2, mem_rd, mem_load_regfile, wb_rd, wb_load_regfile) : FWD_RF;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
        .clk        (clk),
        .rst        (rst),
        .clr        (perf_clr),
        .inc_cycle  (1'b1),
        .inc_istall (ev_istall),
        .inc_dstall (ev_dstall),
        .inc_bubble (ev_bubble),
        .inc_flush  (ev_flush),
        .sel        (perf_sel),
        .data       (perf_data)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic             id_use_rs1, id_use_rs2, ex_dcache_read;
    logic             mem_load_regfile, wb_load_regfile;
    logic             ex_redirect, icache_resp, dcache_req, dcache_resp, perf_clr;
    logic [2:0]       perf_sel;
    logic             load_pc;
    logic             pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb;
    logic             pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb;
    logic [1:0]       rs1mux_sel, rs2mux_sel, stall_state;
    logic [CNT_W-1:0] perf_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int               m_state;
    logic [CNT_W-1:0] m_cnt [5];
    logic [CNT_W-1:0] m_pdata;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_dcache_read(ex_dcache_read),
        .mem_rd(mem_rd), .mem_load_regfile(mem_load_regfile),
        .wb_rd(wb_rd), .wb_load_regfile(wb_load_regfile),
        .ex_redirect(ex_redirect), .icache_resp(icache_resp),
        .dcache_req(dcache_req), .dcache_resp(dcache_resp),
        .perf_clr(perf_clr), .perf_sel(perf_sel),
        .load_pc(load_pc),
        .pipe_load_ifid(pipe_load_ifid), .pipe_load_idex(pipe_load_idex),
        .pipe_load_exmem(pipe_load_exmem), .pipe_load_memwb(pipe_load_memwb),
        .pipe_rst_ifid(pipe_rst_ifid), .pipe_rst_idex(pipe_rst_idex),
        .pipe_rst_exmem(pipe_rst_exmem), .pipe_rst_memwb(pipe_rst_memwb),
        .rs1mux_sel(rs1mux_sel), .rs2mux_sel(rs2mux_sel),
        .stall_state(stall_state), .perf_data(perf_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Outcome: 0 reset, 1 dstall, 2 redirect blocked by istall, 3 redirect, 4 istall, 5 load-use, 6 run
    function automatic int outcome();
        bit lu_hit;
        lu_hit = ex_dcache_read && ex_rd != 0 &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        if (!rst)                       return 0;
        if (dcache_req && !dcache_resp) return 1;
        if (ex_redirect && !icache_resp) return 2;
        if (ex_redirect)                return 3;
        if (!icache_resp)               return 4;
        if (lu_hit)                     return 5;
        return 6;
    endfunction

    // {load_pc, load ifid/idex/exmem/memwb, rst ifid/idex/exmem/memwb}
    function automatic logic [8:0] exp_ctrl(input int oc);
        case (oc)
            0:       return 9'b0_1111_1111;
            1, 2:    return 9'b0_0000_0000;
            3:       return 9'b1_1111_1100;
            4, 5:    return 9'b0_0111_0100;
            default: return 9'b1_1111_0000;
        endcase
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (!rst) return 2'd0;
        if (mem_load_regfile && mem_rd != 0 && mem_rd == rs) return 2'd1;
        if (wb_load_regfile && wb_rd != 0 && wb_rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    // Compare everything at the falling edge, then advance the model at the rising edge.
    task automatic step();
        int oc;
        @(negedge clk);
        oc = outcome();
        check_eq("ctrl", {load_pc, pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb,
                          pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb}, exp_ctrl(oc));
        check_eq("rs1mux", rs1mux_sel, exp_fwd(ex_rs1));
        check_eq("rs2mux", rs2mux_sel, exp_fwd(ex_rs2));
        check_eq("stall_state", stall_state, m_state);
        check_eq("perf_data", perf_data, m_pdata);
        @(posedge clk);
        if (oc == 0) begin
            m_state = 0;
            m_pdata = '0;
            for (int i = 0; i < 5; i++) m_cnt[i] = '0;
        end else begin
            m_pdata = (perf_sel < 5) ? m_cnt[perf_sel] : '0;
            if (perf_clr) begin
                for (int i = 0; i < 5; i++) m_cnt[i] = '0;
            end else begin
                m_cnt[0] = m_cnt[0] + 1;
                if (oc == 2 || oc == 4) m_cnt[1] = m_cnt[1] + 1;
                if (oc == 1)            m_cnt[2] = m_cnt[2] + 1;
                if (oc == 5)            m_cnt[3] = m_cnt[3] + 1;
                if (oc == 3)            m_cnt[4] = m_cnt[4] + 1;
            end
            m_state = (oc == 1) ? 2 : (oc == 2 || oc == 4) ? 1 : (oc == 5) ? 3 : 0;
        end
        #1;
    endtask

    task automatic quiet();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_dcache_read = 0;
        mem_rd = 0; mem_load_regfile = 0; wb_rd = 0; wb_load_regfile = 0;
        ex_redirect = 0; icache_resp = 1; dcache_req = 0; dcache_resp = 0;
        perf_clr = 0; perf_sel = 0;
    endtask

    task automatic clear_counters();
        perf_clr = 1; step(); perf_clr = 0;
    endtask

    initial begin
        m_state = 0; m_pdata = '0;
        for (int i = 0; i < 5; i++) m_cnt[i] = '0;
        quiet();
        rst = 0;
        step(); step();
        check_eq("rst_load_pc", load_pc, 0);
        check_eq("rst_rst_memwb", pipe_rst_memwb, 1);

        // Free run: cycles counter reaches 10 after 10 cycles
        rst = 1;
        for (int i = 0; i < 11; i++) step();
        check_eq("run_cycles10", perf_data, 10);
        check_eq("run_load_pc", load_pc, 1);
        check_eq("run_state", stall_state, 0);

        // Load-use: single bubble
        clear_counters();
        ex_dcache_read = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5;
        #1;
        check_eq("lu_load_pc", load_pc, 0);
        check_eq("lu_rst_idex", pipe_rst_idex, 1);
        step();
        ex_dcache_read = 0; perf_sel = 3;
        step();
        check_eq("lu_state_run", stall_state, 0);
        check_eq("lu_bubble1", perf_data, 1);

        // Load-use on x0 never stalls
        ex_dcache_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        #1;
        check_eq("lu_x0_load_pc", load_pc, 1);
        step();
        quiet();

        // Forwarding priority
        mem_rd = 7; wb_rd = 7; mem_load_regfile = 1; wb_load_regfile = 1; ex_rs1 = 7;
        #1;
        check_eq("fwd_mem", rs1mux_sel, 2'b01);
        step();
        mem_load_regfile = 0;
        #1;
        check_eq("fwd_wb", rs1mux_sel, 2'b10);
        step();
        quiet();

        // Redirect held behind a data-cache stall
        clear_counters();
        ex_redirect = 1; dcache_req = 1; dcache_resp = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("ds_freeze", {load_pc, pipe_load_ifid, pipe_load_memwb, pipe_rst_idex}, 0);
            step();
            check_eq("ds_state", stall_state, 2);
        end
        dcache_resp = 1;
        #1;
        check_eq("ds_redirect", {load_pc, pipe_rst_ifid, pipe_rst_idex}, 3'b111);
        step();
        ex_redirect = 0; dcache_req = 0; dcache_resp = 0; perf_sel = 4;
        step();
        check_eq("ds_flush1", perf_data, 1);

        // Redirect held behind an instruction-cache miss
        clear_counters();
        ex_redirect = 1; icache_resp = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("is_freeze", {load_pc, pipe_load_ifid, pipe_load_idex, pipe_load_exmem}, 0);
            step();
        end
        icache_resp = 1;
        #1;
        check_eq("is_redirect", {load_pc, pipe_rst_ifid, pipe_rst_idex}, 3'b111);
        step();
        ex_redirect = 0; perf_sel = 1;
        step();
        check_eq("is_istall3", perf_data, 3);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst              = ($urandom_range(0, 49) != 0);
            id_rs1           = 5'($urandom_range(0, 3));
            id_rs2           = 5'($urandom_range(0, 3));
            id_use_rs1       = 1'($urandom);
            id_use_rs2       = 1'($urandom);
            ex_rs1           = 5'($urandom_range(0, 3));
            ex_rs2           = 5'($urandom_range(0, 3));
            ex_rd            = 5'($urandom_range(0, 3));
            ex_dcache_read   = 1'($urandom);
            mem_rd           = 5'($urandom_range(0, 3));
            mem_load_regfile = 1'($urandom);
            wb_rd            = 5'($urandom_range(0, 3));
            wb_load_regfile  = 1'($urandom);
            ex_redirect      = ($urandom_range(0, 3) == 0);
            icache_resp      = ($urandom_range(0, 3) != 0);
            dcache_req       = 1'($urandom);
            dcache_resp      = 1'($urandom);
            perf_clr         = ($urandom_range(0, 39) == 0);
            perf_sel         = 3'($urandom_range(0, 7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Consumes decoded register fields, stage valid/write flags, cache handshakes and EX branch resolution.
- Produces the pipe_load_*, pipe_rst_*, load_pc, rs1mux_sel and rs2mux_sel fields of the control struct.
- Tracks the stall reason in a small FSM and keeps readable performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_dcache_read  in  1  EX instruction is a load.
- mem_rd  in  5  destination register in MEM.
- mem_load_regfile  in  1  MEM instruction writes the regfile.
- wb_rd  in  5  destination register in WB.
- wb_load_regfile  in  1  WB instruction writes the regfile.
- ex_redirect  in  1  EX resolved a taken branch or jump.
- icache_resp  in  1  fetch data valid this cycle.
- dcache_req  in  1  MEM stage has a read or write outstanding.
- dcache_resp  in  1  dcache access completes this cycle.
- perf_clr  in  1  synchronously clear all counters.
- perf_sel  in  3  counter select.
- load_pc  out  1  PC register load enable.
- pipe_load_ifid, pipe_load_idex, pipe_load_exmem, pipe_load_memwb  out  1 each  stage register load enables.
- pipe_rst_ifid, pipe_rst_idex, pipe_rst_exmem, pipe_rst_memwb  out  1 each  load a bubble into the stage register.
- rs1mux_sel, rs2mux_sel  out  2 each  EX operand forwarding selects.
- stall_state  out  2  registered FSM state.
- perf_data  out  CNT_W  registered value of the selected counter.

Behaviour:
- Reset (rst low at a clock edge):
  - FSM goes to RUN; all counters and perf_data go to 0.
  - While rst is low, all outputs are forced: load_pc=0, every pipe_load_*=1, every pipe_rst_*=1, fwd selects=0.
- Stall terms, all combinational and evaluated in the same cycle:
  - dstall = dcache_req & ~dcache_resp.
  - istall = ~icache_resp.
  - lu = ex_dcache_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority is dstall > redirect > istall > lu > run.
  - dstall: every load and rst signal = 0, so all stages freeze. A redirect asserted in this cycle is held in EX and takes effect once dstall drops.
  - ex_redirect & icache_resp: load_pc=1, all stages load, rst_ifid=1, rst_idex=1 (squash two younger instructions).
  - ex_redirect & istall: the whole pipe freezes until icache_resp, so the in-flight fetch address stays stable. The redirect then applies as in the previous case.
  - istall (no redirect): load_pc=0, load_ifid=0. idex/exmem/memwb load, and rst_idex=1 inserts a bubble.
  - lu: same as istall. The bubble is exactly one cycle, because the load then leaves EX and lu drops.
  - run: load_pc=1, all stages load, no rst.
- Forwarding (rsN = ex_rs1 / ex_rs2):
  - 2'b01 (MEM ALU result) when mem_load_regfile & mem_rd!=0 & mem_rd==rsN.
  - Else 2'b10 (WB data) when wb_load_regfile & wb_rd!=0 & wb_rd==rsN.
  - Else 2'b00 (regfile). MEM wins over WB. Selects are independent of stalls.
- FSM (stall_state, registered from the priority outcome each cycle): RUN=0, ISTALL=1, DSTALL=2, BUBBLE=3.
  - A redirect cycle and a run cycle both record RUN.
  - A redirect blocked by istall or dstall records ISTALL or DSTALL respectively.
- Counters: cycles, istall, dstall, bubble (lu cycles), flush (applied redirects).
  - Each increments on the cycle its condition is true and wraps modulo 2^CNT_W.
  - perf_clr has priority over increment.
  - perf_sel: 0=cycles, 1=istall, 2=dstall, 3=bubble, 4=flush; 5-7 read 0.
  - perf_data updates one cycle after perf_sel changes.

Decomposition:
- hazard_pkg holds:
  - stall_state_t enum (RUN, ISTALL, DSTALL, BUBBLE);
  - fwd_sel_t enum (FWD_RF=0, FWD_MEM=1, FWD_WB=2);
  - perf_sel constants.
- Sub-module hazard_perf_cnt: five counters, clear, select, registered read port.

Test Plan:
- Reset then release, icache_resp=1, no hazards -> load_pc=1, all pipe_load=1, no rst, stall_state=0, and cycles counter=10 after 10 cycles.
- ex_dcache_read=1, ex_rd=5, id_use_rs1=1, id_rs1=5 -> one cycle with load_pc=0, load_ifid=0, rst_idex=1, then RUN, and bubble counter=1.
- Same load-use with id_rs1=0 and ex_rd=0 -> no stall.
- mem_rd=wb_rd=7 with both write flags set, ex_rs1=7 -> rs1mux_sel=01. Clear mem_load_regfile -> rs1mux_sel=10.
- dcache_req=1 with dcache_resp low for 4 cycles while ex_redirect=1 -> all loads and rsts 0 for 4 cycles, stall_state=2. On the resp cycle, load_pc=1 with rst_ifid and rst_idex set, and flush counter=1.
- ex_redirect=1 with icache_resp low for 3 cycles -> pipe frozen and load_pc=0 for 3 cycles. Redirect applies on the resp cycle, and the istall counter reads 3 (perf_sel=1).
